hazard_scheduler: RTL and testbench

//   Pipeline sequencer for the 5-stage MIPS core. Drives stall/flush of the IF/ID and ID/EX pipeline

---
 rtl/hazard_scheduler.sv | 169 ++++++++++++++++
 tb/tb_hazard_scheduler.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scheduler.sv
// Hazard unit and mul/div sequencer for the 5-stage MIPS pipeline.
// It generates the stall and flush controls and selects the forwarding paths.
// It also times the multi-cycle MULT/DIV unit and counts stalled cycles.
module hazard_scheduler #(
    parameter int unsigned MulCycles = 4,
    parameter int unsigned DivCycles = 32,
    parameter int unsigned CntW      = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      rs_d_i,
    input  logic [4:0]      rt_d_i,
    input  logic [4:0]      rs_e_i,
    input  logic [4:0]      rt_e_i,
    input  logic [4:0]      write_reg_e_i,
    input  logic [4:0]      write_reg_m_i,
    input  logic [4:0]      write_reg_w_i,
    input  logic            reg_write_e_i,
    input  logic            reg_write_m_i,
    input  logic            reg_write_w_i,
    input  logic            mem_to_reg_e_i,
    input  logic            mem_to_reg_m_i,
    input  logic            branch_d_i,
    input  logic            pc_src_d_i,
    input  logic            jump_d_i,
    input  logic            hilo_read_d_i,
    input  logic            muldiv_d_i,
    input  logic            muldiv_start_e_i,
    input  logic            muldiv_op_e_i,
    output logic            stall_f_o,
    output logic            stall_d_o,
    output logic            flush_d_o,
    output logic            flush_e_o,
    output logic            forward_a_d_o,
    output logic            forward_b_d_o,
    output logic [1:0]      forward_a_e_o,
    output logic [1:0]      forward_b_e_o,
    output logic            muldiv_busy_o,
    output logic            hilo_we_o,
    output logic            muldiv_err_o,
    output logic [CntW-1:0] stall_count_o
);

    // The latency counter only has to hold (longest latency - 1).
    localparam int unsigned MaxCycles = (DivCycles > MulCycles) ? DivCycles : MulCycles;
    localparam int unsigned CycW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CycW-1:0] MulLoad = CycW'(MulCycles - 1);
    localparam logic [CycW-1:0] DivLoad = CycW'(DivCycles - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } md_state_e;

    md_state_e        state_q;
    logic [CycW-1:0]  cnt_q;
    logic             busy_q;
    logic             hilo_we_q;
    logic             err_q;
    logic [CntW-1:0]  stall_cnt_q;

    logic lw_stall;
    logic br_stall;
    logic md_stall;
    logic stall;

    // $0 is hard-wired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // Forwarding mux selects. M is newer than W, so M takes priority.
    always_comb begin
        forward_a_e_o = 2'b00;
        forward_b_e_o = 2'b00;
        if (reg_write_m_i && reg_hit(write_reg_m_i, rs_e_i)) begin
            forward_a_e_o = 2'b10;
        end else if (reg_write_w_i && reg_hit(write_reg_w_i, rs_e_i)) begin
            forward_a_e_o = 2'b01;
        end
        if (reg_write_m_i && reg_hit(write_reg_m_i, rt_e_i)) begin
            forward_b_e_o = 2'b10;
        end else if (reg_write_w_i && reg_hit(write_reg_w_i, rt_e_i)) begin
            forward_b_e_o = 2'b01;
        end
        forward_a_d_o = reg_write_m_i && reg_hit(write_reg_m_i, rs_d_i);
        forward_b_d_o = reg_write_m_i && reg_hit(write_reg_m_i, rt_d_i);
    end

    // Hazard detection. Stalls are asserted as soon as the inputs show a hazard.
    always_comb begin
        lw_stall = mem_to_reg_e_i &&
                   (reg_hit(write_reg_e_i, rs_d_i) || reg_hit(write_reg_e_i, rt_d_i));
        br_stall = branch_d_i &&
                   ((reg_write_e_i &&
                     (reg_hit(write_reg_e_i, rs_d_i) || reg_hit(write_reg_e_i, rt_d_i))) ||
                    (mem_to_reg_m_i &&
                     (reg_hit(write_reg_m_i, rs_d_i) || reg_hit(write_reg_m_i, rt_d_i))));
        md_stall = (busy_q || muldiv_start_e_i) && (hilo_read_d_i || muldiv_d_i);
        stall    = lw_stall || br_stall || md_stall;

        stall_f_o = stall;
        stall_d_o = stall;
        flush_e_o = stall;
        // A redirect is dropped while D is held; it re-presents next cycle.
        flush_d_o = (pc_src_d_i || jump_d_i) && !stall;
    end

    // Mul/div sequencer. busy and the HI/LO strobe are registered with the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hilo_we_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (muldiv_start_e_i) begin
                        state_q <= StBusy;
                        cnt_q   <= muldiv_op_e_i ? DivLoad : MulLoad;
                        busy_q  <= 1'b1;
                    end
                end
                StBusy: begin
                    if (muldiv_start_e_i) begin
                        err_q <= 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_q   <= StDone;
                        hilo_we_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CycW'(1);
                    end
                end
                StDone: begin
                    if (muldiv_start_e_i) begin
                        err_q <= 1'b1;
                    end
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                end
                default: begin
                    state_q   <= StIdle;
                    busy_q    <= 1'b0;
                    hilo_we_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CntW'(1);
        end
    end

    assign muldiv_busy_o = busy_q;
    assign hilo_we_o     = hilo_we_q;
    assign muldiv_err_o  = err_q;
    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scheduler.sv
// Bench for hazard_scheduler. It runs directed vectors against a behavioural model.
// A second instance with a 4-bit stall counter exercises saturation.
module tb_hazard_scheduler;

    localparam int unsigned MulN = 4;
    localparam int unsigned DivN = 32;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic [4:0] rs_d = '0, rt_d = '0, rs_e = '0, rt_e = '0;
    logic [4:0] write_reg_e = '0, write_reg_m = '0, write_reg_w = '0;
    logic       reg_write_e = 0, reg_write_m = 0, reg_write_w = 0;
    logic       mem_to_reg_e = 0, mem_to_reg_m = 0;
    logic       branch_d = 0, pc_src_d = 0, jump_d = 0;
    logic       hilo_read_d = 0, muldiv_d = 0, muldiv_start_e = 0, muldiv_op_e = 0;

    logic        stall_f, stall_d, flush_d, flush_e, fwd_ad, fwd_bd;
    logic [1:0]  fwd_ae, fwd_be;
    logic        busy, hilo_we, err;
    logic [15:0] stall_count;

    logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e, s_fwd_ad, s_fwd_bd;
    logic [1:0]  s_fwd_ae, s_fwd_be;
    logic        s_busy, s_hilo_we, s_err;
    logic [3:0]  s_stall_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_scheduler #(.MulCycles(MulN), .DivCycles(DivN), .CntW(16)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .rs_d_i(rs_d), .rt_d_i(rt_d), .rs_e_i(rs_e), .rt_e_i(rt_e),
        .write_reg_e_i(write_reg_e), .write_reg_m_i(write_reg_m), .write_reg_w_i(write_reg_w),
        .reg_write_e_i(reg_write_e), .reg_write_m_i(reg_write_m), .reg_write_w_i(reg_write_w),
        .mem_to_reg_e_i(mem_to_reg_e), .mem_to_reg_m_i(mem_to_reg_m),
        .branch_d_i(branch_d), .pc_src_d_i(pc_src_d), .jump_d_i(jump_d),
        .hilo_read_d_i(hilo_read_d), .muldiv_d_i(muldiv_d),
        .muldiv_start_e_i(muldiv_start_e), .muldiv_op_e_i(muldiv_op_e),
        .stall_f_o(stall_f), .stall_d_o(stall_d), .flush_d_o(flush_d), .flush_e_o(flush_e),
        .forward_a_d_o(fwd_ad), .forward_b_d_o(fwd_bd),
        .forward_a_e_o(fwd_ae), .forward_b_e_o(fwd_be),
        .muldiv_busy_o(busy), .hilo_we_o(hilo_we), .muldiv_err_o(err),
        .stall_count_o(stall_count)
    );

    hazard_scheduler #(.MulCycles(MulN), .DivCycles(DivN), .CntW(4)) u_dut_small (
        .clk_i(clk), .rst_ni(rst_ni),
        .rs_d_i(rs_d), .rt_d_i(rt_d), .rs_e_i(rs_e), .rt_e_i(rt_e),
        .write_reg_e_i(write_reg_e), .write_reg_m_i(write_reg_m), .write_reg_w_i(write_reg_w),
        .reg_write_e_i(reg_write_e), .reg_write_m_i(reg_write_m), .reg_write_w_i(reg_write_w),
        .mem_to_reg_e_i(mem_to_reg_e), .mem_to_reg_m_i(mem_to_reg_m),
        .branch_d_i(branch_d), .pc_src_d_i(pc_src_d), .jump_d_i(jump_d),
        .hilo_read_d_i(hilo_read_d), .muldiv_d_i(muldiv_d),
        .muldiv_start_e_i(muldiv_start_e), .muldiv_op_e_i(muldiv_op_e),
        .stall_f_o(s_stall_f), .stall_d_o(s_stall_d), .flush_d_o(s_flush_d),
        .flush_e_o(s_flush_e), .forward_a_d_o(s_fwd_ad), .forward_b_d_o(s_fwd_bd),
        .forward_a_e_o(s_fwd_ae), .forward_b_e_o(s_fwd_be),
        .muldiv_busy_o(s_busy), .hilo_we_o(s_hilo_we), .muldiv_err_o(s_err),
        .stall_count_o(s_stall_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_rem   = 0;   // unit-occupied cycles still to go (0 = free)
    bit m_err   = 0;
    int m_cnt   = 0;
    int m_cnt_s = 0;

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
        if (reg_write_m && hit(write_reg_m, src)) return 2'b10;
        if (reg_write_w && hit(write_reg_w, src)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_stall();
        bit lw, br, md;
        lw = mem_to_reg_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d));
        br = branch_d && ((reg_write_e && (hit(write_reg_e, rs_d) || hit(write_reg_e, rt_d))) ||
                          (mem_to_reg_m && (hit(write_reg_m, rs_d) || hit(write_reg_m, rt_d))));
        md = ((m_rem > 0) || muldiv_start_e) && (hilo_read_d || muldiv_d);
        return lw || br || md;
    endfunction

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_rem = 0; m_err = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            if (exp_stall()) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt_s < 15) m_cnt_s++;
            end
            if (m_rem == 0) begin
                if (muldiv_start_e) m_rem = (muldiv_op_e ? DivN : MulN) + 1;
            end else begin
                if (muldiv_start_e) m_err = 1;
                m_rem--;
            end
        end
    end

    // Compare every cycle, mid-cycle.
    always @(negedge clk) begin
        bit st;
        st = exp_stall();
        chk("stall_f", stall_f, st);
        chk("stall_d", stall_d, st);
        chk("flush_e", flush_e, st);
        chk("flush_d", flush_d, (pc_src_d || jump_d) && !st);
        chk("fwd_ad", fwd_ad, reg_write_m && hit(write_reg_m, rs_d));
        chk("fwd_bd", fwd_bd, reg_write_m && hit(write_reg_m, rt_d));
        chk("fwd_ae", fwd_ae, exp_fwd_e(rs_e));
        chk("fwd_be", fwd_be, exp_fwd_e(rt_e));
        chk("busy", busy, m_rem > 0);
        chk("hilo_we", hilo_we, m_rem == 1);
        chk("err", err, m_err);
        chk("stall_count", stall_count, m_cnt);
        chk("small_stall_count", s_stall_count, m_cnt_s);
        chk("small_busy", s_busy, m_rem > 0);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
        write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
        reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
        mem_to_reg_e = 0; mem_to_reg_m = 0;
        branch_d = 0; pc_src_d = 0; jump_d = 0;
        hilo_read_d = 0; muldiv_d = 0; muldiv_start_e = 0; muldiv_op_e = 0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_hilo_we", hilo_we, 0);
        chk("rst_err", err, 0);
        chk("rst_count", stall_count, 0);
        tick();
        rst_ni = 1;

        // Forwarding: M wins over W; $0 never forwards
        reg_write_m = 1; write_reg_m = 5; reg_write_w = 1; write_reg_w = 5; rs_e = 5;
        @(negedge clk); chk("lit_fwd_ae_m", fwd_ae, 2'b10);
        tick(); rs_e = 0;
        @(negedge clk); chk("lit_fwd_ae_r0", fwd_ae, 2'b00);
        tick(); reg_write_m = 0; rt_e = 5; rt_d = 5;
        @(negedge clk); chk("lit_fwd_be_w", fwd_be, 2'b01);
        tick(); reg_write_m = 1; write_reg_m = 7; rt_d = 7; reg_write_w = 0;
        @(negedge clk); chk("lit_fwd_bd", fwd_bd, 1);

        // Load-use stall for one cycle
        tick(); clear_inputs();
        mem_to_reg_e = 1; write_reg_e = 8; rt_d = 8;
        @(negedge clk);
        chk("lit_lw_stall", stall_d, 1);
        chk("lit_lw_cnt0", stall_count, 0);
        tick(); clear_inputs();
        @(negedge clk);
        chk("lit_lw_cnt1", stall_count, 1);
        chk("lit_lw_gone", stall_d, 0);
        tick(); mem_to_reg_e = 1; write_reg_e = 0; rs_d = 0;
        @(negedge clk); chk("lit_lw_r0", stall_d, 0);

        // Branch hazard holds back the redirect
        tick(); clear_inputs();
        branch_d = 1; reg_write_e = 1; write_reg_e = 3; rs_d = 3; pc_src_d = 1;
        @(negedge clk);
        chk("lit_br_stall", stall_d, 1);
        chk("lit_br_noflush", flush_d, 0);
        tick(); reg_write_e = 0;
        @(negedge clk);
        chk("lit_br_flush", flush_d, 1);
        tick(); reg_write_e = 0; mem_to_reg_m = 1; write_reg_m = 3; jump_d = 1;
        @(negedge clk); chk("lit_br_load_m", stall_d, 1);

        // MULT with an MFHI held in D
        tick(); clear_inputs();
        muldiv_start_e = 1; muldiv_op_e = 0; hilo_read_d = 1;
        @(negedge clk);
        chk("lit_md_start_stall", stall_d, 1);
        chk("lit_md_start_busy", busy, 0);
        tick(); muldiv_start_e = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_md_busy", busy, 1);
            chk("lit_md_stall", stall_d, 1);
            chk("lit_md_hilo_we", hilo_we, (i == 4));
            tick();
        end
        @(negedge clk);
        chk("lit_md_idle", busy, 0);
        chk("lit_md_nostall", stall_d, 0);

        // DIV abandoned by reset
        tick(); clear_inputs();
        muldiv_start_e = 1; muldiv_op_e = 1;
        tick(); muldiv_start_e = 0;
        repeat (9) tick();
        @(negedge clk);
        #1 rst_ni = 0;
        #1;
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_hilo", hilo_we, 0);
        chk("lit_rst_count", stall_count, 0);
        tick(); tick();
        rst_ni = 1;
        muldiv_start_e = 1; muldiv_op_e = 0;
        tick(); muldiv_start_e = 0;
        repeat (4) tick();
        @(negedge clk); chk("lit_restart_hilo", hilo_we, 1);
        tick();
        @(negedge clk); chk("lit_restart_idle", busy, 0);

        // Counter saturation on the 4-bit instance
        tick(); clear_inputs();
        mem_to_reg_e = 1; write_reg_e = 8; rs_d = 8;
        repeat (20) tick();
        @(negedge clk);
        chk("lit_sat_small", s_stall_count, 15);
        chk("lit_sat_main", stall_count, 20);

        // Second start while busy is flagged
        tick(); clear_inputs();
        muldiv_start_e = 1;
        tick();
        tick(); muldiv_start_e = 0;
        @(negedge clk);
        chk("lit_err", err, 1);
        chk("lit_err_busy", busy, 1);
        repeat (6) tick();
        @(negedge clk);
        chk("lit_err_sticky", err, 1);
        chk("lit_err_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
